// File: rtl/bls_div_pkg.sv
// Shared types and constants for the nibble-serial restoring divider.
package bls_div_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    SUB    = 3'd2,
    DECIDE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int NIBBLE = 4;

  function automatic int nslice(input int width);
    return width / NIBBLE;
  endfunction

endpackage

// File: rtl/bls4_slice.sv
// Combinational 4-bit subtract slice with borrow lookahead: Diff = X - Y - Bin.
module bls4_slice (
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       Bin,
  output logic [3:0] Diff,
  output logic       Bout
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_b;

  // A bit borrows when x<y, and propagates an incoming borrow when x==y.
  assign w_p = ~(X ^ Y);
  assign w_g = ~X & Y;

  assign w_b[0] = Bin;
  assign w_b[1] = w_g[0] | (w_p[0] & Bin);
  assign w_b[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & Bin);
  assign w_b[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & Bin);
  assign w_b[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Bin);

  assign Diff = X ^ Y ^ w_b[3:0];
  assign Bout = w_b[4];

endmodule

// File: rtl/bls_restoring_divider.sv
// Sequential unsigned restoring divider; one shared 4-bit slice walks the
// trial subtraction nibble by nibble with a registered borrow between nibbles.
module bls_restoring_divider
  import bls_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int NIBW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int BCW    = $clog2(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_rem, r_q, r_t, r_dreg;
  logic [WIDTH-1:0] r_quot, r_remout;
  logic             r_b, r_done, r_dbz;
  logic [NIBW-1:0]  r_nib;
  logic [BCW-1:0]   r_bitcnt;

  logic [3:0]       w_x, w_y, w_diff;
  logic             w_bout, w_last_nib, w_last_bit;
  logic [WIDTH-1:0] w_new_rem, w_new_q;

  bls4_slice u_slice (
    .X    (w_x),
    .Y    (w_y),
    .Bin  (r_b),
    .Diff (w_diff),
    .Bout (w_bout)
  );

  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (r_nib == NIBW'(i)) begin
        w_x = r_rem[i*NIBBLE +: NIBBLE];
        w_y = r_dreg[i*NIBBLE +: NIBBLE];
      end
    end
  end

  assign w_last_nib = (r_nib == NIBW'(NSLICE - 1));
  assign w_last_bit = (r_bitcnt == BCW'(WIDTH - 1));
  // Final borrow clear means R >= D: keep the trial difference.
  assign w_new_rem  = r_b ? r_rem : r_t;
  assign w_new_q    = {r_q[WIDTH-1:1], ~r_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (divisor == '0) ? DONE : SHIFT;
      SHIFT:   w_state_nxt = SUB;
      SUB:     if (w_last_nib) w_state_nxt = DECIDE;
      DECIDE:  w_state_nxt = w_last_bit ? DONE : SHIFT;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result registers load on the edge entering DONE so they are valid with done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem    <= '0;
      r_q      <= '0;
      r_t      <= '0;
      r_dreg   <= '0;
      r_b      <= 1'b0;
      r_nib    <= '0;
      r_bitcnt <= '0;
      r_quot   <= '0;
      r_remout <= '0;
      r_dbz    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_q      <= dividend;
            r_dreg   <= divisor;
            r_rem    <= '0;
            r_bitcnt <= '0;
            if (divisor == '0) begin
              r_quot   <= '1;
              r_remout <= dividend;
              r_dbz    <= 1'b1;
              r_done   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_rem <= {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
          r_q   <= {r_q[WIDTH-2:0], 1'b0};
          r_nib <= '0;
          r_b   <= 1'b0;
        end
        SUB: begin
          for (int unsigned i = 0; i < NSLICE; i++) begin
            if (r_nib == NIBW'(i)) r_t[i*NIBBLE +: NIBBLE] <= w_diff;
          end
          r_b   <= w_bout;
          r_nib <= r_nib + NIBW'(1);
        end
        DECIDE: begin
          r_rem    <= w_new_rem;
          r_q      <= w_new_q;
          r_bitcnt <= r_bitcnt + BCW'(1);
          if (w_last_bit) begin
            r_quot   <= w_new_q;
            r_remout <= w_new_rem;
            r_dbz    <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready       = (r_state == IDLE);
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_remout;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_bls_restoring_divider.sv
// Directed and random checks of the restoring divider at WIDTH=8 and WIDTH=16.
module tb_bls_restoring_divider;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  n8 = '0, d8 = '0;
  logic [15:0] n16 = '0, d16 = '0;
  logic        ready8, done8, dbz8, ready16, done16, dbz16;
  logic [7:0]  q8, r8;
  logic [15:0] q16, r16;

  bls_restoring_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .dividend(n8), .divisor(d8),
    .ready(ready8), .done(done8), .quotient(q8), .remainder(r8),
    .div_by_zero(dbz8)
  );

  bls_restoring_divider #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .dividend(n16), .divisor(d16),
    .ready(ready16), .done(done16), .quotient(q16), .remainder(r16),
    .div_by_zero(dbz16)
  );

  logic        sel16 = 1'b0;
  logic        m_ready, m_done, m_dbz;
  logic [15:0] m_q, m_r;
  assign m_ready = sel16 ? ready16 : ready8;
  assign m_done  = sel16 ? done16  : done8;
  assign m_dbz   = sel16 ? dbz16   : dbz8;
  assign m_q     = sel16 ? q16 : {8'h00, q8};
  assign m_r     = sel16 ? r16 : {8'h00, r8};

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t last8  = '{q: 16'h0, r: 16'h0, dbz: 1'b0};
  exp_t last16 = '{q: 16'h0, r: 16'h0, dbz: 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input bit wide, input logic [15:0] n, input logic [15:0] d);
    exp_t e;
    if (d == 16'h0) begin
      e.q = wide ? 16'hFFFF : 16'h00FF;
      e.r = n;
      e.dbz = 1'b1;
    end else begin
      e.q = n / d;
      e.r = n % d;
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  task automatic drive(input bit wide, input logic s, input logic [15:0] n, input logic [15:0] d);
    if (wide) begin
      start16 = s; n16 = n; d16 = d;
    end else begin
      start8 = s; n8 = n[7:0]; d8 = d[7:0];
    end
  endtask

  // One operation: accept, optional ignored re-request, latency and result checks.
  task automatic do_op(input bit wide, input logic [15:0] n, input logic [15:0] d,
                       input int rep_at);
    exp_t e, got, prev;
    int   lat, exp_lat, w;
    sel16   = wide;
    w       = wide ? 16 : 8;
    exp_lat = (d == 16'h0) ? 1 : w * (w / 4 + 2) + 1;
    prev    = wide ? last16 : last8;
    lat = 0;
    while (!m_ready && lat < 300) begin
      tick();
      lat++;
    end
    chk("ready_idle", 32'(m_ready), 32'd1);
    sb.push_back(model(wide, n, d));
    drive(wide, 1'b1, n, d);
    tick();
    lat = 1;
    drive(wide, 1'b0, 16'h5A5A, 16'h0003);
    chk("ready_drop", 32'(m_ready), 32'd0);
    while (!m_done && lat < 400) begin
      if (lat == 5) begin
        chk("hold_q", 32'(m_q), 32'(prev.q));
        chk("hold_r", 32'(m_r), 32'(prev.r));
      end
      drive(wide, (rep_at != 0 && lat == rep_at), 16'h0009, 16'h0009);
      tick();
      lat++;
    end
    drive(wide, 1'b0, 16'h0, 16'h0);
    chk("done_seen", 32'(m_done), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got.q = m_q; got.r = m_r; got.dbz = m_dbz;
      chk("quotient", 32'(got.q), 32'(e.q));
      chk("remainder", 32'(got.r), 32'(e.r));
      chk("div_by_zero", 32'(got.dbz), 32'(e.dbz));
      if (wide) last16 = e;
      else      last8  = e;
    end else begin
      chk("scoreboard_nonempty", 32'(sb.size()), 32'd1);
    end
    tick();
    chk("done_pulse_end", 32'(m_done), 32'd0);
    chk("ready_return", 32'(m_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic [15:0] rn, rd;

    // Reset state, visible before any clock edge.
    #2;
    chk("rst_ready", 32'(ready8), 32'd1);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_q", 32'(q8), 32'd0);
    chk("rst_r", 32'(r8), 32'd0);
    chk("rst_dbz", 32'(dbz8), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    do_op(1'b0, 16'd200, 16'd7, 0);
    do_op(1'b0, 16'd255, 16'd1, 0);
    do_op(1'b0, 16'd5,   16'd9, 0);
    do_op(1'b0, 16'd13,  16'd0, 0);
    do_op(1'b0, 16'd100, 16'd10, 0);
    do_op(1'b0, 16'd100, 16'd3, 10);

    // Asynchronous abort mid-operation.
    sel16 = 1'b0;
    drive(1'b0, 1'b1, 16'd200, 16'd7);
    tick();
    drive(1'b0, 1'b0, 16'd0, 16'd0);
    for (lat = 1; lat < 15; lat++) tick();
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", 32'(ready8), 32'd1);
    chk("abort_q", 32'(q8), 32'd0);
    chk("abort_r", 32'(r8), 32'd0);
    chk("abort_dbz", 32'(dbz8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done8) chk("abort_no_done", 32'(done8), 32'd0);
    end
    last8 = '{q: 16'h0, r: 16'h0, dbz: 1'b0};
    do_op(1'b0, 16'd50, 16'd5, 0);

    do_op(1'b1, 16'd65535, 16'd255, 0);
    do_op(1'b1, 16'd1234,  16'd0, 0);

    for (int i = 0; i < 1000; i++) begin
      rn = 16'($urandom_range(0, 255));
      rd = (i % 50 == 0) ? 16'h0 : 16'($urandom_range(0, 255));
      do_op(1'b0, rn, rd, 0);
    end
    for (int i = 0; i < 60; i++) begin
      rn = 16'($urandom_range(0, 65535));
      rd = (i % 20 == 0) ? 16'h0 : 16'($urandom_range(1, 65535) >> $urandom_range(0, 15));
      do_op(1'b1, rn, rd, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bls_restoring_divider.md
Name: bls_restoring_divider

Overview:
Sequential unsigned restoring divider built around a single 4-bit borrow-lookahead subtract slice, time-multiplexed nibble by nibble.
- Each quotient bit takes one shift cycle, WIDTH/4 nibble-subtract cycles with a registered borrow chain, and one decide cycle.
- Start/ready/done handshake.
- Sits between the operand registers of the arithmetic lab datapath and the result display/consumer logic.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived; number of nibble-subtract cycles per quotient bit. Not overridable.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- dividend  in  WIDTH  unsigned N; sampled on the accepting edge.
- divisor  in  WIDTH  unsigned D; sampled on the accepting edge.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse; quotient, remainder and div_by_zero are valid from this cycle.
- quotient  out  WIDTH  registered result.
- remainder  out  WIDTH  registered result.
- div_by_zero  out  1  registered; set when D=0 for the completed operation.

Behaviour:
- Reset (async, rst=1): state=IDLE; all internal registers 0; quotient=0, remainder=0, div_by_zero=0, done=0; ready=1 once in IDLE.
- States: IDLE, SHIFT, SUB, DECIDE, DONE. Internal registers:
  - R: WIDTH-bit partial remainder.
  - Q: WIDTH-bit shifting dividend/quotient.
  - T: WIDTH-bit trial difference.
  - b: 1-bit borrow.
  - nib: nibble index.
  - bitcnt: bit counter.
- IDLE, start=1:
  - Latch Q=N, Dreg=D; R=0; bitcnt=0.
  - If D=0, go to DONE with div_by_zero result pending; otherwise go to SHIFT.
- SHIFT: R={R[WIDTH-2:0],Q[WIDTH-1]}; Q=Q<<1; nib=0; b=0. Next state SUB.
- SUB, one nibble per cycle, LSB nibble first:
  - Slice inputs: X=R[4*nib+3:4*nib], Y=Dreg[4*nib+3:4*nib], Bin=b.
  - Capture T[4*nib+3:4*nib]=Diff and b=Bout.
  - nib increments. After nib=NSLICE-1, go to DECIDE.
- DECIDE:
  - If b=0 (R>=D): R=T, Q[0]=1. Otherwise R unchanged, Q[0]=0.
  - bitcnt increments. Go to DONE if bitcnt was WIDTH-1, else SHIFT.
- No overflow bit is needed: before the k-th shift, R < min(D, 2^(k-1)), so the shifted R always fits in WIDTH bits.
- DONE:
  - Normal path: quotient=Q, remainder=R, div_by_zero=0.
  - D=0 path: quotient=all ones, remainder=N, div_by_zero=1.
  - done=1 for exactly this cycle. Next state IDLE.
- Latency, counted in edges from the accepting edge to the cycle in which done=1:
  - D≠0: WIDTH*(NSLICE+2)+1 (33 for WIDTH=8).
  - D=0: 1.
- Back-to-back: ready is low in DONE. A new start is accepted on the first IDLE cycle, so the minimum issue interval is latency+1.
- start while ready=0 is ignored, with no queuing. Operand changes while busy have no effect.
- Output registers hold their value from done until the next done. They do not change during a computation.
- rst asserted mid-operation aborts immediately: state IDLE, outputs 0, no done pulse.

Decomposition:
- Package bls_div_pkg holds:
  - state enum: IDLE, SHIFT, SUB, DECIDE, DONE (binary encoded);
  - localparam NIBBLE=4;
  - a function computing NSLICE from WIDTH.
- One sub-module, bls4_slice: a combinational 4-bit borrow-lookahead subtract slice.
  - Inputs X[3:0], Y[3:0], Bin. Outputs Diff[3:0], Bout.
  - P=~(X^Y), G=~X&Y; lookahead borrows; Diff=X^Y^borrow-in per bit.
- The controller instantiates exactly one bls4_slice and muxes nibbles into it.

Test Plan:
- WIDTH=8, N=200, D=7, pulse start -> ready drops next cycle; done pulses exactly 33 edges after accept; quotient=28, remainder=4, div_by_zero=0.
- N=255, D=1 -> quotient=255, remainder=0. Then N=5, D=9 -> quotient=0, remainder=5. Also check that outputs keep 255/0 until the second done.
- N=13, D=0 -> done 1 edge after accept; quotient=8'hFF, remainder=13, div_by_zero=1. A following 100/10 -> quotient=10, remainder=0, div_by_zero=0.
- Start N=100, D=3; re-pulse start with N=9, D=9 at cycle 10 -> second request ignored; result 33 r1 at edge 33; ready back to 1 at edge 34.
- Start N=200, D=7; assert rst asynchronously mid-cycle at edge 15 -> all outputs 0 and ready=1 without waiting for a clock edge; no done pulse. After release, 50/5 -> 10 r0.
- WIDTH=16 (NSLICE=4): N=65535, D=255 -> quotient=257, remainder=0; done at 16*6+1=97 edges. Random sweep of 1000 operand pairs against a reference model.
